imem_loader: RTL and testbench

- Writer-side counterpart of the single-cycle CPU core: streams a program into the CPU's instruction/data memory before execution, then releases the core.
- Accepts a byte stream over a valid/ready handshake and assembles 32-bit little-endian words.
- Drives a single-port memory write interface.
- Holds the CPU in reset until the load completes.

---
 rtl/imem_loader_if.sv | 21 ++
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and word-write memory bus for the program loader
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a little-endian program into instruction memory, holds the CPU until loaded
// Optional trailing XOR checksum byte: define LOADER_CHKSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  imem_loader_if.slave bus,
  output logic         cpu_hold_o,
  output logic         done_o,
  output logic         error_o
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BYTES,
    S_WRITE,
`ifdef LOADER_CHKSUM_EN
    S_CHK,
`endif
    S_FIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              accept;
`ifdef LOADER_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
  logic              err_q, err_d;
`endif

  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
`ifdef LOADER_CHKSUM_EN
    chk_d   = chk_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          done_d  = 1'b0;
          hold_d  = 1'b1;
          addr_d  = BASE;
          state_d = S_HDR;
`ifdef LOADER_CHKSUM_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_HDR: begin
        if (accept) begin
          if (bus.in_data == 8'd0) begin
            state_d = S_FIN;
          end else begin
            cnt_d   = bus.in_data;
            idx_d   = 2'd0;
            state_d = S_BYTES;
`ifdef LOADER_CHKSUM_EN
            chk_d   = bus.in_data;
`endif
          end
        end
      end
      S_BYTES: begin
        if (accept) begin
          wdata_d[{idx_q, 3'b000} +: 8] = bus.in_data;
          idx_d = idx_q + 2'd1;
`ifdef LOADER_CHKSUM_EN
          chk_d = chk_q ^ bus.in_data;
`endif
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // Address wraps naturally at 2^ADDR_W.
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q != 8'd1) begin
          state_d = S_BYTES;
        end else begin
`ifdef LOADER_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_FIN;
`endif
        end
      end
`ifdef LOADER_CHKSUM_EN
      S_CHK: begin
        if (accept) begin
          err_d   = (bus.in_data != chk_q);
          state_d = S_FIN;
        end
      end
`endif
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_DONE;
`ifdef LOADER_CHKSUM_EN
        hold_d  = err_q;
`else
        hold_d  = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered from the next state so they align with it.
    in_ready_d = (state_d == S_HDR) || (state_d == S_BYTES);
`ifdef LOADER_CHKSUM_EN
    if (state_d == S_CHK) in_ready_d = 1'b1;
`endif
    mem_we_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= 2'd0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= BASE;
      wdata_q    <= 32'd0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      chk_q      <= 8'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
`ifdef LOADER_CHKSUM_EN
      chk_q      <= chk_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_hold_o    = hold_q;
  assign done_o        = done_q;
`ifdef LOADER_CHKSUM_EN
  assign error_o       = err_q;
`else
  assign error_o       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard bench for imem_loader (8-bit and wrapping 2-bit address builds)
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       hold, done, err;
  logic       hold_w, done_w, err_w;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) bus ();
  imem_loader_if #(.ADDR_W(2)) busw ();

  assign bus.in_data   = in_data;
  assign bus.in_valid  = in_valid;
  assign busw.in_data  = in_data;
  assign busw.in_valid = in_valid;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus),
    .cpu_hold_o(hold), .done_o(done), .error_o(err)
  );

  imem_loader #(.ADDR_W(2), .BASE_ADDR(3)) dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bus(busw),
    .cpu_hold_o(hold_w), .done_o(done_w), .error_o(err_w)
  );

  int          errors = 0;
  int          checks = 0;
  logic [39:0] q_m[$];
  logic [39:0] q_w[$];
  int          am, aw;
  logic [7:0]  cs;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (q_m.size() == 0) check("spurious_we_m", 40'(bus.mem_we), 40'd0);
      else check("write_m", {bus.mem_addr, bus.mem_wdata}, q_m.pop_front());
    end
    if (busw.mem_we === 1'b1) begin
      if (q_w.size() == 0) check("spurious_we_w", 40'(busw.mem_we), 40'd0);
      else check("write_w", {6'd0, busw.mem_addr, busw.mem_wdata}, q_w.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 40'(bus.in_ready), 40'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    q_m.push_back({am[7:0], w});
    q_w.push_back({6'd0, aw[1:0], w});
    am = (am + 1) % 256;
    aw = (aw + 1) % 4;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      cs = cs ^ w[8*k +: 8];
      if (stall && k == 1) begin
        repeat (5) begin
          @(negedge clk);
          check("stall_ready", 40'(bus.in_ready), 40'd1);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic begin_load(input logic [7:0] n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_hold", 40'(hold), 40'd1);
    check("start_done", 40'(done), 40'd0);
    am = 0;
    aw = 3;
    cs = n;
    send_byte(n);
  endtask

  task automatic finish_load();
`ifdef LOADER_CHKSUM_EN
    send_byte(cs);
`endif
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check("done_reached", 40'(done), 40'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 40'(bus.in_ready), 40'd0);
    check({tag, "_we"}, 40'(bus.mem_we), 40'd0);
    check({tag, "_addr"}, 40'(bus.mem_addr), 40'd0);
    check({tag, "_addr_w"}, 40'(busw.mem_addr), 40'd3);
    check({tag, "_wdata"}, 40'(bus.mem_wdata), 40'd0);
    check({tag, "_hold"}, 40'(hold), 40'd1);
    check({tag, "_done"}, 40'(done), 40'd0);
    check({tag, "_err"}, 40'(err), 40'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    am = 0; aw = 3; cs = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two-word program; the 2-bit build writes addr 3 then wraps to 0.
    begin_load(8'd2);
    send_word(32'h00500013, 1'b0);
    send_word(32'h00A00093, 1'b0);
`ifdef LOADER_CHKSUM_EN
    finish_load();
    wait_done();
`else
    @(posedge clk); #1;
    check("fin_done", 40'(done), 40'd0);
    check("fin_hold", 40'(hold), 40'd1);
    @(posedge clk); #1;
    check("done_done", 40'(done), 40'd1);
    check("done_hold", 40'(hold), 40'd0);
    in_data = 8'hAA;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("done_ignores_stream", 40'(bus.in_ready), 40'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
`endif
    check("load1_err", 40'(err), 40'd0);
    check("load1_done_w", 40'(done_w), 40'd1);
    check("load1_hold", 40'(hold), 40'd0);

    // Empty program straight from DONE.
    begin_load(8'd0);
    wait_done();
    check("n0_addr", 40'(bus.mem_addr), 40'd0);
    check("n0_addr_w", 40'(busw.mem_addr), 40'd3);
    check("n0_hold", 40'(hold), 40'd0);

    // Five-cycle stall mid-word.
    begin_load(8'd1);
    send_word(32'h12345678, 1'b1);
    finish_load();
    wait_done();
    check("stall_hold", 40'(hold), 40'd0);

    // Reset after six bytes of a three-word load, then a fresh load.
    begin_load(8'd3);
    send_word(32'hCAFEF00D, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    begin_load(8'd1);
    send_word(32'hDEADBEEF, 1'b0);
    finish_load();
    wait_done();
    check("reload_hold", 40'(hold), 40'd0);

`ifdef LOADER_CHKSUM_EN
    begin_load(8'd1);
    send_word(32'h04030201, 1'b0);
    send_byte(8'h05);
    wait_done();
    check("cs_good_err", 40'(err), 40'd0);
    check("cs_good_hold", 40'(hold), 40'd0);

    begin_load(8'd1);
    send_word(32'h04030201, 1'b0);
    send_byte(8'h06);
    wait_done();
    check("cs_bad_err", 40'(err), 40'd1);
    check("cs_bad_hold", 40'(hold), 40'd1);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_m_empty", 40'(q_m.size()), 40'd0);
    check("queue_w_empty", 40'(q_w.size()), 40'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
